// File: rtl/red_pitaya_asg_sweep_ch.sv
// One ASG channel: waveform table, fractional phase accumulator with linear step sweep,
// burst/repeat sequencing and scale/offset/saturate to the DAC. Build option: ASG_SWEEP_PINGPONG_EN.
module red_pitaya_asg_sweep_ch #(
    parameter int RSZ = 14,
    parameter int DW  = 14,
    parameter int FW  = 32
) (
    input  logic              dac_clk_i,
    input  logic              dac_rstn_i,
    output logic [DW-1:0]     dac_o,
    input  logic              trig_i,
    output logic              trig_done_o,
    input  logic              buf_we_i,
    input  logic [RSZ-1:0]    buf_addr_i,
    input  logic [DW-1:0]     buf_wdata_i,
    output logic [DW-1:0]     buf_rdata_o,
    output logic [RSZ-1:0]    buf_rpnt_o,
    input  logic [RSZ-1:0]    set_size_i,
    input  logic [RSZ-1:0]    set_ofs_i,
    input  logic [RSZ+FW-1:0] set_step_start_i,
    input  logic [RSZ+FW-1:0] set_step_stop_i,
    input  logic [RSZ+FW-1:0] set_sweep_inc_i,
    input  logic [31:0]       set_sweep_div_i,
    input  logic              set_rst_i,
    input  logic              set_zero_i,
    input  logic [DW-1:0]     set_amp_i,
    input  logic [DW-1:0]     set_dc_i,
    input  logic [DW-1:0]     set_last_i,
    input  logic [15:0]       set_ncyc_i,
    input  logic [15:0]       set_rnum_i,
    input  logic [31:0]       set_rdly_i,
    output logic              sweep_act_o
);
    localparam int SW = RSZ + FW;

    typedef enum logic [1:0] {IDLE, RUN, DELAY, LAST} state_t;
    state_t state;

    logic [SW-1:0] pnt, step, per_len, pnt_nxt, step_mv, target;
    logic [SW:0]   pnt_sum, step_inc, step_gap;
    logic [15:0]   ncnt, bcnt;
    logic [31:0]   dcnt, sdiv;
    logic          wrap, run_end, more, dly_done, trig_ok, restart, burst_go;
`ifdef ASG_SWEEP_PINGPONG_EN
    logic          sdir;  // 1: heading to stop, 0: heading back to start
`endif

    always_comb begin
        pnt_sum  = {1'b0, pnt} + {1'b0, step};
        per_len  = {set_size_i + RSZ'(1), {FW{1'b0}}};
        wrap     = pnt_sum[SW:FW] > {1'b0, set_size_i};
        pnt_nxt  = wrap ? pnt_sum[SW-1:0] - per_len : pnt_sum[SW-1:0];
        run_end  = wrap && (set_ncyc_i != 16'd0) && (ncnt <= 16'd1);
        more     = (set_rnum_i == 16'd0) || (bcnt > 16'd1);
        dly_done = ({1'b0, dcnt} + 33'd1) >= {1'b0, set_rdly_i};
        trig_ok  = trig_i && (state == IDLE || state == LAST);
        restart  = (state == RUN && run_end && more && set_rdly_i == 32'd0) ||
                   (state == DELAY && dly_done);
        burst_go = !set_rst_i && (trig_ok || restart);
    end

    // Move the step one increment toward the current target, clamping on arrival.
    always_comb begin
`ifdef ASG_SWEEP_PINGPONG_EN
        target = sdir ? set_step_stop_i : set_step_start_i;
`else
        target = set_step_stop_i;
`endif
        step_inc = {1'b0, step} + {1'b0, set_sweep_inc_i};
        step_gap = {1'b0, step} - {1'b0, target};
        if (target >= step)
            step_mv = (step_inc >= {1'b0, target}) ? target : step_inc[SW-1:0];
        else
            step_mv = (step_gap <= {1'b0, set_sweep_inc_i}) ? target : step - set_sweep_inc_i;
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state       <= IDLE;
            pnt         <= '0;
            step        <= '0;
            ncnt        <= '0;
            bcnt        <= '0;
            dcnt        <= '0;
            sdiv        <= '0;
            trig_done_o <= 1'b0;
            sweep_act_o <= 1'b0;
            buf_rpnt_o  <= '0;
`ifdef ASG_SWEEP_PINGPONG_EN
            sdir        <= 1'b1;
`endif
        end else begin
            trig_done_o <= 1'b0;
            buf_rpnt_o  <= pnt[SW-1:FW];
            sweep_act_o <= (state == RUN) && (set_sweep_inc_i != '0) && (step != set_step_stop_i);
            if (set_rst_i) begin
                state <= IDLE;
                pnt   <= {set_ofs_i, {FW{1'b0}}};
                step  <= '0;
                ncnt  <= '0;
                bcnt  <= '0;
                dcnt  <= '0;
                sdiv  <= '0;
            end else if (burst_go) begin
                state <= RUN;
                pnt   <= {set_ofs_i, {FW{1'b0}}};
                step  <= set_step_start_i;
                ncnt  <= set_ncyc_i;
                dcnt  <= '0;
                sdiv  <= '0;
`ifdef ASG_SWEEP_PINGPONG_EN
                sdir  <= 1'b1;
`endif
                if (trig_ok) begin
                    bcnt        <= set_rnum_i;
                    trig_done_o <= 1'b1;
                end else if (state == RUN && set_rnum_i != 16'd0) begin
                    bcnt <= bcnt - 16'd1;
                end
            end else begin
                case (state)
                    IDLE:  pnt <= {set_ofs_i, {FW{1'b0}}};
                    RUN: begin
                        pnt <= pnt_nxt;
                        if (set_sweep_inc_i != '0) begin
                            if (sdiv >= set_sweep_div_i) begin
                                sdiv <= '0;
                                step <= step_mv;
`ifdef ASG_SWEEP_PINGPONG_EN
                                if (step_mv == target) sdir <= ~sdir;
`endif
                            end else begin
                                sdiv <= sdiv + 32'd1;
                            end
                        end
                        if (run_end) begin
                            if (more) begin
                                state <= DELAY;
                                dcnt  <= '0;
                                if (set_rnum_i != 16'd0) bcnt <= bcnt - 16'd1;
                            end else begin
                                state <= LAST;
                            end
                        end else if (wrap && set_ncyc_i != 16'd0) begin
                            ncnt <= ncnt - 16'd1;
                        end
                    end
                    DELAY: dcnt <= dcnt + 32'd1;
                    LAST:  ;
                endcase
            end
        end
    end

    // Waveform table: playback read sees pre-write data on an address collision.
    logic [DW-1:0] mem [0:(1<<RSZ)-1];

    always_ff @(posedge dac_clk_i) begin
        if (buf_we_i) mem[buf_addr_i] <= buf_wdata_i;
    end

    logic [RSZ-1:0]       raddr;
    logic [DW-1:0]        rdat;
    logic signed [DW-1:0] dreg;
    logic signed [2*DW:0] prod;
    logic [DW+2:0]        sum;
    logic [DW-1:0]        sat;
    logic [4:1]           lst_pipe;
    logic [5:1]           zero_pipe;
    logic                 unused_prod_lsb;

    assign unused_prod_lsb = ^prod[DW-2:0];

    always_comb begin
        sum = {prod[2*DW], prod[2*DW:DW-1]} + {{3{set_dc_i[DW-1]}}, set_dc_i};
        if (&sum[DW+2:DW-1] || ~|sum[DW+2:DW-1])
            sat = sum[DW-1:0];
        else
            sat = sum[DW+2] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            raddr       <= '0;
            rdat        <= '0;
            dreg        <= '0;
            prod        <= '0;
            lst_pipe    <= '0;
            zero_pipe   <= '0;
            dac_o       <= '0;
            buf_rdata_o <= '0;
        end else begin
            buf_rdata_o <= mem[buf_addr_i];
            raddr       <= pnt[SW-1:FW];
            rdat        <= mem[raddr];
            dreg        <= rdat;
            prod        <= dreg * $signed({1'b0, set_amp_i});
            lst_pipe    <= {lst_pipe[3:1], (state == DELAY || state == LAST)};
            zero_pipe   <= {zero_pipe[4:1], set_zero_i};
            if (set_zero_i || |zero_pipe) dac_o <= '0;
            else if (lst_pipe[4])         dac_o <= set_last_i;
            else                          dac_o <= sat;
        end
    end

endmodule
